serial_deframer: RTL and testbench

- Serial-to-parallel receiver: the far end of the 8-bit loadable shift register used as a parallel-to-serial transmitter.
- Samples one serial bit per qualified clock and assembles W-bit words, MSB-first or LSB-first.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags a word lost to backpressure on a sticky overflow flag.

---
 rtl/serial_deframer.sv | 97 +++++++++
 tb/tb_serial_deframer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deframer.sv
// serial_deframer: serial-to-parallel word receiver with valid/ready output and sticky overflow; SERIAL_DEFRAMER_PARITY_EN adds a trailing even-parity bit and perr
module serial_deframer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         si,
  input  logic         sv,
  input  logic         sof,
  input  logic         msb_first,
  output logic [W-1:0] q,
  output logic         qv,
`ifdef SERIAL_DEFRAMER_PARITY_EN
  output logic         perr,
`endif
  input  logic         qr,
  output logic         ovf,
  input  logic         ovf_clr
);
`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int n_bits = W + 1;
`else
  localparam int n_bits = W;
`endif
  localparam int cw = $clog2(n_bits);
  localparam logic [cw-1:0] n_last = cw'(n_bits - 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [W-1:0] sh, sh_n, word;
  logic ord, ord_n, done;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic par_c;
  assign word = sh;
  assign par_c = ^{sh, si};
`else
  assign word = sh_n;
`endif
  // state, bit counter, shift register and latched bit order
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ord <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      ord <= ord_n;
    end
  end
  // sof restarts a word from any state; plain bits are only taken while receiving
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    ord_n = ord;
    done = 1'b0;
    if (sv && sof) begin
      state_n = RECV;
      ord_n = msb_first;
      cnt_n = cw'(1);
      sh_n = msb_first ? {{(W-1){1'b0}}, si} : {si, {(W-1){1'b0}}};
    end else if (sv && state == RECV) begin
      done = cnt == n_last;
      cnt_n = done ? '0 : cnt + cw'(1);
`ifdef SERIAL_DEFRAMER_PARITY_EN
      sh_n = done ? sh : (ord ? {sh[W-2:0], si} : {si, sh[W-1:1]});
`else
      sh_n = ord ? {sh[W-2:0], si} : {si, sh[W-1:1]};
`endif
    end
  end
  // output register: a completed word is accepted when the slot is free or draining, otherwise dropped
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q <= '0;
      qv <= 1'b0;
      ovf <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      if (done && (!qv || qr)) begin
        q <= word;
        qv <= 1'b1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
        perr <= par_c;
`endif
      end else if (qv && qr) begin
        qv <= 1'b0;
      end
      ovf <= (done && qv && !qr) || (ovf && !ovf_clr);
    end
  end
endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed self-checking bench for serial_deframer
module tb_serial_deframer;
  logic clk, nrst, si, sv, sof, msb_first, qr, ovf_clr;
  logic [7:0] q;
  logic qv, ovf;
  int total, bad;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic perr;
`endif

  serial_deframer #(.W(8)) dut (
    .clk(clk), .nrst(nrst), .si(si), .sv(sv), .sof(sof), .msb_first(msb_first),
    .q(q), .qv(qv),
`ifdef SERIAL_DEFRAMER_PARITY_EN
    .perr(perr),
`endif
    .qr(qr), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    si = b;
    sof = s;
    sv = 1'b1;
    tick();
    sv = 1'b0;
    sof = 1'b0;
  endtask

  // msb_first is driven to the wrong order on non-sof beats to show it is ignored; gap cycles wiggle si and sof with sv=0
  task automatic send_word(input logic [7:0] v, input logic msb, input logic first_sof, input int nb, input int gap);
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < gap; g++) begin
        si = ~si;
        sof = 1'b1;
        sv = 1'b0;
        tick();
      end
      msb_first = (i == 0 && first_sof) ? msb : ~msb;
      send_bit(msb ? v[7-i] : v[i], i == 0 && first_sof);
    end
    sof = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    tick();
    tick();
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b exp=0", qv); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`ifdef SERIAL_DEFRAMER_PARITY_EN
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", perr); end
`endif
    nrst = 1'b1;
    qr = 1'b1;
    send_word(8'hFF, 1'b1, 1'b0, 10, 0);
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL idle_ignore_qv got=%b exp=0", qv); end
  endtask

  task automatic test_msb;
    qr = 1'b1;
    send_word(8'hA5, 1'b1, 1'b1, 7, 0);
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL msb_early_qv got=%b exp=0", qv); end
    msb_first = 1'b0;
    send_bit(1'b1, 1'b0);
    total++; if (qv !== 1'b1) begin bad++; $display("FAIL msb_qv got=%b exp=1", qv); end
    total++; if (q !== 8'hA5) begin bad++; $display("FAIL msb_q got=%h exp=a5", q); end
    tick();
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL msb_drop_qv got=%b exp=0", qv); end
    total++; if (q !== 8'hA5) begin bad++; $display("FAIL msb_hold_q got=%h exp=a5", q); end
  endtask

  task automatic test_lsb;
    send_word(8'h8D, 1'b0, 1'b1, 8, 0);
    total++; if (q !== 8'h8D || qv !== 1'b1) begin bad++; $display("FAIL lsb_word got=%h/%b exp=8d/1", q, qv); end
    tick();
  endtask

  task automatic test_stall;
    send_word(8'hA5, 1'b1, 1'b1, 8, 2);
    total++; if (q !== 8'hA5 || qv !== 1'b1) begin bad++; $display("FAIL stall_word got=%h/%b exp=a5/1", q, qv); end
    tick();
  endtask

  task automatic test_restart;
    send_word(8'hE0, 1'b1, 1'b1, 3, 0);
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL restart_partial_qv got=%b exp=0", qv); end
    send_word(8'h3C, 1'b1, 1'b1, 8, 0);
    total++; if (q !== 8'h3C || qv !== 1'b1) begin bad++; $display("FAIL restart_word got=%h/%b exp=3c/1", q, qv); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL restart_ovf got=%b exp=0", ovf); end
    tick();
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL restart_single_qv got=%b exp=0", qv); end
  endtask

  task automatic test_backpressure;
    qr = 1'b0;
    send_word(8'h11, 1'b1, 1'b1, 8, 0);
    total++; if (q !== 8'h11 || qv !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL bp_first got=%h/%b/%b exp=11/1/0", q, qv, ovf); end
    send_word(8'h22, 1'b1, 1'b0, 8, 0);
    total++; if (q !== 8'h11 || qv !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b exp=11/1", q, qv); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
    qr = 1'b1;
    tick();
    total++; if (qv !== 1'b0 || ovf !== 1'b1) begin bad++; $display("FAIL bp_drain got=%b/%b exp=0/1", qv, ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp_clr got=%b exp=0", ovf); end
  endtask

  task automatic test_back_to_back;
    qr = 1'b0;
    send_word(8'h11, 1'b1, 1'b1, 8, 0);
    send_word(8'h22, 1'b1, 1'b0, 7, 0);
    total++; if (q !== 8'h11 || qv !== 1'b1) begin bad++; $display("FAIL b2b_pre got=%h/%b exp=11/1", q, qv); end
    qr = 1'b1;
    send_bit(1'b0, 1'b0);
    total++; if (q !== 8'h22 || qv !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL b2b_swap got=%h/%b/%b exp=22/1/0", q, qv, ovf); end
    qr = 1'b0;
    ovf_clr = 1'b1;
    send_word(8'h33, 1'b1, 1'b0, 8, 0);
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b1 || q !== 8'h22) begin bad++; $display("FAIL set_wins got=%b/%h exp=1/22", ovf, q); end
    qr = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0 || qv !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%b exp=0/0", ovf, qv); end
  endtask

  task automatic test_midreset;
    qr = 1'b1;
    send_word(8'hF0, 1'b1, 1'b1, 3, 0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    total++; if (qv !== 1'b0 || q !== 8'h00 || ovf !== 1'b0) begin bad++; $display("FAIL midreset got=%h/%b/%b exp=00/0/0", q, qv, ovf); end
    send_word(8'h8D, 1'b0, 1'b1, 8, 0);
    total++; if (q !== 8'h8D || qv !== 1'b1) begin bad++; $display("FAIL midreset_next got=%h/%b exp=8d/1", q, qv); end
    tick();
  endtask

`ifdef SERIAL_DEFRAMER_PARITY_EN
  task automatic test_parity;
    qr = 1'b1;
    send_word(8'hA5, 1'b1, 1'b1, 8, 0);
    total++; if (qv !== 1'b0) begin bad++; $display("FAIL par_wait_qv got=%b exp=0", qv); end
    send_bit(1'b0, 1'b0);
    total++; if (q !== 8'hA5 || qv !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL par_good got=%h/%b/%b exp=a5/1/0", q, qv, perr); end
    send_word(8'hA5, 1'b1, 1'b1, 8, 0);
    send_bit(1'b1, 1'b0);
    total++; if (q !== 8'hA5 || qv !== 1'b1 || perr !== 1'b1) begin bad++; $display("FAIL par_bad got=%h/%b/%b exp=a5/1/1", q, qv, perr); end
    send_word(8'hF0, 1'b1, 1'b1, 3, 0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    total++; if (qv !== 1'b0 || perr !== 1'b0) begin bad++; $display("FAIL par_reset got=%b/%b exp=0/0", qv, perr); end
    send_word(8'h3C, 1'b1, 1'b1, 8, 0);
    send_bit(1'b0, 1'b0);
    total++; if (q !== 8'h3C || qv !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL par_next got=%h/%b/%b exp=3c/1/0", q, qv, perr); end
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    nrst = 1'b0;
    si = 1'b0;
    sv = 1'b0;
    sof = 1'b0;
    msb_first = 1'b0;
    qr = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
`ifdef SERIAL_DEFRAMER_PARITY_EN
    test_parity();
`else
    test_msb();
    test_lsb();
    test_stall();
    test_restart();
    test_backpressure();
    test_back_to_back();
    test_midreset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
